// File: rtl/axis_lane_deser_if.sv
// AXI4-Stream bus bundle for the lane deserialiser output.
//   tvalid / tready : beat handshake (master drives tvalid, slave drives tready)
//   tdata           : AXIS_NUM_BYTES*8 bit beat payload
//   tkeep           : byte enables, driven all-ones by the deserialiser
//   tlast           : final beat of a packet
//   tuser           : first beat of a packet
// The master modport is used by the deserialiser, the slave modport by a sink.
interface axis_lane_deser_if #(
    parameter int AXIS_NUM_BYTES = 4
);
    logic                          tvalid;
    logic                          tready;
    logic [AXIS_NUM_BYTES*8-1:0]   tdata;
    logic [AXIS_NUM_BYTES-1:0]     tkeep;
    logic                          tlast;
    logic                          tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/axis_lane_deser.sv
// Serial-lane to AXI4-Stream deserialiser with ping-pong packet buffering.
//   clk               : single rising-edge clock
//   rstn              : asynchronous active-low reset
//   serial_i          : LANES serial bits per valid cycle (bit LANES-1 most significant)
//   serial_valid_i    : serial_i carries data this cycle
//   words_in_packet_i : packet length in words, sampled on each packet's first word
//   m_axis            : AXIS master (tvalid/tready/tdata/tkeep/tlast/tuser)
//   overflow_o        : one-cycle pulse when a packet has been discarded
//   drop_cnt_o        : saturating count of discarded packets
// A writer fills one bank of RAM while a reader drains the other; a packet
// arriving while its target bank is still full is discarded.
module axis_lane_deser #(
    parameter int AXIS_NUM_BYTES = 4,
    parameter int LANES          = 1,
    parameter int BUF_WORDS      = 512,
    parameter int MSB_FIRST      = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [LANES-1:0]     serial_i,
    input  logic                 serial_valid_i,
    input  logic [31:0]          words_in_packet_i,
    axis_lane_deser_if.master    m_axis,
    output logic                 overflow_o,
    output logic [15:0]          drop_cnt_o
);
    localparam int W      = AXIS_NUM_BYTES * 8;
    localparam int GROUPS = W / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int AW     = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
    localparam int LW     = AW + 1;

    typedef enum logic       {W_FILL, W_DROP} wrState_t;
    typedef enum logic [1:0] {R_IDLE, R_PREFETCH, R_SEND} rdState_t;

    logic [W-1:0]         shift_q, shift_d;
    logic [CW-1:0]        grpCnt_q, grpCnt_d;
    wrState_t             wrState_q, wrState_d;
    logic                 wrBank_q, wrBank_d;
    logic [LW-1:0]        wrPtr_q, wrPtr_d;
    logic [LW-1:0]        wrLen_q, wrLen_d;
    logic [1:0]           full_q, full_d;
    logic [1:0][LW-1:0]   bankLen_q, bankLen_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          dropCnt_q, dropCnt_d;
    rdState_t             rdState_q, rdState_d;
    logic                 rdBank_q, rdBank_d;
    logic [LW-1:0]        outIdx_q, outIdx_d;
    logic                 tvalid_q, tvalid_d;
    logic [W-1:0]         tdata_q, tdata_d;
    logic                 tuser_q, tuser_d;
    logic                 tlast_q, tlast_d;

    logic [W-1:0]         mem [2*BUF_WORDS];
    logic [W-1:0]         ramRd_q;
    logic                 ramWe, ramRe;
    logic [AW:0]          ramWaddr, ramRaddr;

    logic [W-1:0]         shifted;
    logic                 wordDone;
    logic [LW-1:0]        reqLen;
    logic [LW-1:0]        curLen;
    logic                 setFull, clrFull, dropPulse;

    // Next-state logic for deserialiser, writer and reader. The RAM output
    // register only loads when a read is issued, so during a stall it keeps
    // holding the word after the one on the bus; that is what lets the reader
    // stream one beat per cycle without a separate skid buffer.
    always_comb begin
        shift_d    = shift_q;
        grpCnt_d   = grpCnt_q;
        wrState_d  = wrState_q;
        wrBank_d   = wrBank_q;
        wrPtr_d    = wrPtr_q;
        wrLen_d    = wrLen_q;
        full_d     = full_q;
        bankLen_d  = bankLen_q;
        overflow_d = 1'b0;
        dropCnt_d  = dropCnt_q;
        rdState_d  = rdState_q;
        rdBank_d   = rdBank_q;
        outIdx_d   = outIdx_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tuser_d    = tuser_q;
        tlast_d    = tlast_q;
        ramWe      = 1'b0;
        ramRe      = 1'b0;
        ramWaddr   = {wrBank_q, wrPtr_q[AW-1:0]};
        ramRaddr   = '0;
        setFull    = 1'b0;
        clrFull    = 1'b0;
        dropPulse  = 1'b0;

        if (MSB_FIRST != 0)
            shifted = (shift_q << LANES) | W'(serial_i);
        else
            shifted = (shift_q >> LANES) | (W'(serial_i) << (W - LANES));

        wordDone = serial_valid_i && (grpCnt_q == CW'(GROUPS - 1));
        if (serial_valid_i) begin
            shift_d  = shifted;
            grpCnt_d = wordDone ? '0 : grpCnt_q + CW'(1);
        end

        if (words_in_packet_i == 32'd0)
            reqLen = LW'(1);
        else if (words_in_packet_i > 32'(BUF_WORDS))
            reqLen = LW'(BUF_WORDS);
        else
            reqLen = words_in_packet_i[LW-1:0];

        if (wrState_q == W_FILL) begin
            if (wordDone) begin
                if (wrPtr_q == '0) begin
                    wrLen_d = reqLen;
                    if (full_q[wrBank_q]) begin
                        if (reqLen == LW'(1)) begin
                            dropPulse = 1'b1;
                        end else begin
                            wrState_d = W_DROP;
                            wrPtr_d   = LW'(1);
                        end
                    end else begin
                        ramWe               = 1'b1;
                        bankLen_d[wrBank_q] = reqLen;
                        if (reqLen == LW'(1))
                            setFull = 1'b1;
                        else
                            wrPtr_d = LW'(1);
                    end
                end else begin
                    ramWe = 1'b1;
                    if (wrPtr_q == wrLen_q - LW'(1))
                        setFull = 1'b1;
                    else
                        wrPtr_d = wrPtr_q + LW'(1);
                end
            end
        end else begin
            if (wordDone) begin
                if (wrPtr_q == wrLen_q - LW'(1)) begin
                    dropPulse = 1'b1;
                    wrState_d = W_FILL;
                    wrPtr_d   = '0;
                end else begin
                    wrPtr_d = wrPtr_q + LW'(1);
                end
            end
        end

        if (setFull) begin
            wrBank_d = ~wrBank_q;
            wrPtr_d  = '0;
        end
        if (dropPulse) begin
            overflow_d = 1'b1;
            if (dropCnt_q != 16'hFFFF)
                dropCnt_d = dropCnt_q + 16'd1;
        end

        curLen = bankLen_q[rdBank_q];
        case (rdState_q)
            R_IDLE: begin
                if (full_q[rdBank_q]) begin
                    ramRe     = 1'b1;
                    ramRaddr  = {rdBank_q, AW'(0)};
                    rdState_d = R_PREFETCH;
                end
            end
            R_PREFETCH: begin
                tvalid_d  = 1'b1;
                tdata_d   = ramRd_q;
                tuser_d   = 1'b1;
                tlast_d   = (curLen == LW'(1));
                outIdx_d  = '0;
                ramRe     = 1'b1;
                ramRaddr  = {rdBank_q, AW'(1)};
                rdState_d = R_SEND;
            end
            R_SEND: begin
                if (tvalid_q && m_axis.tready) begin
                    if (outIdx_q == curLen - LW'(1)) begin
                        tvalid_d = 1'b0;
                        tuser_d  = 1'b0;
                        tlast_d  = 1'b0;
                        clrFull  = 1'b1;
                        rdBank_d = ~rdBank_q;
                        outIdx_d = '0;
                        if (full_q[~rdBank_q]) begin
                            ramRe     = 1'b1;
                            ramRaddr  = {~rdBank_q, AW'(0)};
                            rdState_d = R_PREFETCH;
                        end else begin
                            rdState_d = R_IDLE;
                        end
                    end else begin
                        tdata_d  = ramRd_q;
                        tuser_d  = 1'b0;
                        tlast_d  = (outIdx_q + LW'(1) == curLen - LW'(1));
                        outIdx_d = outIdx_q + LW'(1);
                        ramRe    = 1'b1;
                        ramRaddr = {rdBank_q, AW'(outIdx_q + LW'(2))};
                    end
                end
            end
            default: rdState_d = R_IDLE;
        endcase

        // Writer and reader always own different banks, so both updates apply.
        if (setFull)
            full_d[wrBank_q] = 1'b1;
        if (clrFull)
            full_d[rdBank_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q    <= '0;
            grpCnt_q   <= '0;
            wrState_q  <= W_FILL;
            wrBank_q   <= 1'b0;
            wrPtr_q    <= '0;
            wrLen_q    <= '0;
            full_q     <= '0;
            bankLen_q  <= '0;
            overflow_q <= 1'b0;
            dropCnt_q  <= '0;
            rdState_q  <= R_IDLE;
            rdBank_q   <= 1'b0;
            outIdx_q   <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tuser_q    <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            grpCnt_q   <= grpCnt_d;
            wrState_q  <= wrState_d;
            wrBank_q   <= wrBank_d;
            wrPtr_q    <= wrPtr_d;
            wrLen_q    <= wrLen_d;
            full_q     <= full_d;
            bankLen_q  <= bankLen_d;
            overflow_q <= overflow_d;
            dropCnt_q  <= dropCnt_d;
            rdState_q  <= rdState_d;
            rdBank_q   <= rdBank_d;
            outIdx_q   <= outIdx_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
        end
    end

    // Packet RAM: both banks share one array, bank select is the address MSB.
    // Contents are not reset.
    always_ff @(posedge clk) begin
        if (ramWe)
            mem[ramWaddr] <= shifted;
        if (ramRe)
            ramRd_q <= mem[ramRaddr];
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = '1;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = dropCnt_q;
endmodule

// File: tb/tb_axis_lane_deser.sv
// Directed testbench for axis_lane_deser: one instance with single-lane
// MSB-first input and small buffers, one with four lanes LSB-first.
module tb_axis_lane_deser;
    logic        clk;
    logic        rstn;
    logic [0:0]  serial;
    logic        serialValid;
    logic [31:0] wordsInPkt;
    logic        overflow;
    logic [15:0] dropCnt;
    logic [3:0]  serial4;
    logic        serialValid4;
    logic [31:0] wordsInPkt4;
    logic        overflow4;
    logic [15:0] dropCnt4;

    int          checks;
    int          errors;
    logic [31:0] expWords [8];
    int          t;
    int          beatIdx;
    logic [5:0]  readyPat;

    axis_lane_deser_if #(.AXIS_NUM_BYTES(4)) axis ();
    axis_lane_deser_if #(.AXIS_NUM_BYTES(4)) axis4 ();

    axis_lane_deser #(
        .AXIS_NUM_BYTES(4), .LANES(1), .BUF_WORDS(8), .MSB_FIRST(1)
    ) dut (
        .clk(clk), .rstn(rstn), .serial_i(serial), .serial_valid_i(serialValid),
        .words_in_packet_i(wordsInPkt), .m_axis(axis),
        .overflow_o(overflow), .drop_cnt_o(dropCnt)
    );

    axis_lane_deser #(
        .AXIS_NUM_BYTES(4), .LANES(4), .BUF_WORDS(8), .MSB_FIRST(0)
    ) dut4 (
        .clk(clk), .rstn(rstn), .serial_i(serial4), .serial_valid_i(serialValid4),
        .words_in_packet_i(wordsInPkt4), .m_axis(axis4),
        .overflow_o(overflow4), .drop_cnt_o(dropCnt4)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // One comparison: counts it and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Shifts one 32-bit word MSB-first into the single-lane instance,
    // with idle cycles inserted mid-word. Returns on the negedge just after
    // the last bit was sampled.
    task automatic applyStimulus(input logic [31:0] word);
        for (int i = 31; i >= 0; i--) begin
            serial      = word[i];
            serialValid = 1'b1;
            @(negedge clk);
            if (i % 11 == 5) begin
                serialValid = 1'b0;
                serial      = ~word[i];
                @(negedge clk);
            end
        end
        serialValid = 1'b0;
    endtask

    // Waits for tvalid, then checks len back-to-back beats against expWords.
    task automatic expectPacket(input int len, input string tag);
        int n;
        n = 0;
        while (axis.tvalid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_start"}, 32'(axis.tvalid), 32'd1);
        for (int k = 0; k < len; k++) begin
            checkOutput($sformatf("%s_valid%0d", tag, k), 32'(axis.tvalid), 32'd1);
            checkOutput($sformatf("%s_data%0d", tag, k), axis.tdata, expWords[k]);
            checkOutput($sformatf("%s_user%0d", tag, k), 32'(axis.tuser), 32'(k == 0));
            checkOutput($sformatf("%s_last%0d", tag, k), 32'(axis.tlast), 32'(k == len - 1));
            @(negedge clk);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        clk          = 1'b0;
        rstn         = 1'b0;
        serial       = '0;
        serialValid  = 1'b0;
        wordsInPkt   = 32'd4;
        serial4      = '0;
        serialValid4 = 1'b0;
        wordsInPkt4  = 32'd1;
        axis.tready  = 1'b1;
        axis4.tready = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("rst_tvalid", 32'(axis.tvalid), 32'd0);
        checkOutput("rst_tlast", 32'(axis.tlast), 32'd0);
        checkOutput("rst_tuser", 32'(axis.tuser), 32'd0);
        checkOutput("rst_tdata", axis.tdata, 32'd0);
        checkOutput("rst_tkeep", 32'(axis.tkeep), 32'hF);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_dropcnt", 32'(dropCnt), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // L=4 streaming; length input changed mid-packet must not matter.
        wordsInPkt  = 32'd4;
        expWords[0] = 32'hDEADBEEF;
        expWords[1] = 32'h01234567;
        expWords[2] = 32'h89ABCDEF;
        expWords[3] = 32'h00000001;
        applyStimulus(expWords[0]);
        wordsInPkt = 32'd7;
        applyStimulus(expWords[1]);
        applyStimulus(expWords[2]);
        applyStimulus(expWords[3]);
        expectPacket(4, "l4");
        checkOutput("l4_end", 32'(axis.tvalid), 32'd0);

        // L=3 with tready pattern 1,0,0,1,0,1.
        axis.tready = 1'b0;
        wordsInPkt  = 32'd3;
        expWords[0] = 32'hA5A5_0F0F;
        expWords[1] = 32'h1357_9BDF;
        expWords[2] = 32'hFFFF_0000;
        applyStimulus(expWords[0]);
        applyStimulus(expWords[1]);
        applyStimulus(expWords[2]);
        t = 0;
        while (axis.tvalid !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        checkOutput("stall_start", 32'(axis.tvalid), 32'd1);
        readyPat = 6'b101001;
        beatIdx  = 0;
        for (int s = 0; s < 6; s++) begin
            axis.tready = readyPat[s];
            checkOutput($sformatf("stall_valid%0d", s), 32'(axis.tvalid), 32'd1);
            checkOutput($sformatf("stall_data%0d", s), axis.tdata, expWords[beatIdx]);
            checkOutput($sformatf("stall_user%0d", s), 32'(axis.tuser), 32'(beatIdx == 0));
            checkOutput($sformatf("stall_last%0d", s), 32'(axis.tlast), 32'(beatIdx == 2));
            if (readyPat[s]) beatIdx++;
            @(negedge clk);
        end
        axis.tready = 1'b1;
        checkOutput("stall_nodup0", 32'(axis.tvalid), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("stall_nodup1", 32'(axis.tvalid), 32'd0);

        // Three L=2 packets with sink blocked: third one is dropped.
        axis.tready = 1'b0;
        wordsInPkt  = 32'd2;
        applyStimulus(32'h1111_0001);
        applyStimulus(32'h1111_0002);
        applyStimulus(32'h2222_0001);
        applyStimulus(32'h2222_0002);
        applyStimulus(32'h3333_0001);
        checkOutput("ovf_early", 32'(overflow), 32'd0);
        applyStimulus(32'h3333_0002);
        checkOutput("ovf_pulse", 32'(overflow), 32'd1);
        @(negedge clk);
        checkOutput("ovf_clear", 32'(overflow), 32'd0);
        checkOutput("ovf_dropcnt", 32'(dropCnt), 32'd1);
        axis.tready = 1'b1;
        expWords[0] = 32'h1111_0001;
        expWords[1] = 32'h1111_0002;
        expectPacket(2, "p1");
        expWords[0] = 32'h2222_0001;
        expWords[1] = 32'h2222_0002;
        expectPacket(2, "p2");
        repeat (10) @(negedge clk);
        checkOutput("p3_absent", 32'(axis.tvalid), 32'd0);

        // Single-beat packets: L=1 and L=0.
        wordsInPkt  = 32'd1;
        expWords[0] = 32'hCAFE_F00D;
        applyStimulus(expWords[0]);
        expectPacket(1, "len1");
        checkOutput("len1_end", 32'(axis.tvalid), 32'd0);
        wordsInPkt  = 32'd0;
        expWords[0] = 32'h1234_5678;
        applyStimulus(expWords[0]);
        expectPacket(1, "len0");
        checkOutput("len0_end", 32'(axis.tvalid), 32'd0);

        // Length above buffer size clamps to 8 words.
        wordsInPkt = 32'd20;
        for (int i = 0; i < 8; i++) begin
            expWords[i] = 32'h0F0F_0000 + 32'(i * 3 + 1);
            applyStimulus(expWords[i]);
        end
        expectPacket(8, "clamp");
        checkOutput("clamp_end", 32'(axis.tvalid), 32'd0);
        checkOutput("clamp_dropcnt", 32'(dropCnt), 32'd1);

        // Four lanes, LSB-first: nibbles 1..8 with one idle cycle.
        for (int i = 1; i <= 8; i++) begin
            serial4      = 4'(i);
            serialValid4 = 1'b1;
            @(negedge clk);
            if (i == 4) begin
                serialValid4 = 1'b0;
                serial4      = 4'hF;
                @(negedge clk);
            end
        end
        serialValid4 = 1'b0;
        t = 0;
        while (axis4.tvalid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput("lane4_valid", 32'(axis4.tvalid), 32'd1);
        checkOutput("lane4_data", axis4.tdata, 32'h8765_4321);
        checkOutput("lane4_user", 32'(axis4.tuser), 32'd1);
        checkOutput("lane4_last", 32'(axis4.tlast), 32'd1);

        // Reset during an L=8 send with a partial word in the shifter.
        wordsInPkt = 32'd8;
        for (int i = 0; i < 8; i++) begin
            expWords[i] = 32'h5A00_0000 | 32'(i << 8) | 32'(i);
            applyStimulus(expWords[i]);
        end
        t = 0;
        while (axis.tvalid !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        checkOutput("rs_beat0", axis.tdata, expWords[0]);
        @(negedge clk);
        checkOutput("rs_beat1", axis.tdata, expWords[1]);
        axis.tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            serial      = 1'(i % 3);
            serialValid = 1'b1;
            @(negedge clk);
        end
        serialValid = 1'b0;
        checkOutput("rs_hold", axis.tdata, expWords[1]);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("rs_tvalid", 32'(axis.tvalid), 32'd0);
        checkOutput("rs_tdata", axis.tdata, 32'd0);
        checkOutput("rs_tuser", 32'(axis.tuser), 32'd0);
        checkOutput("rs_tlast", 32'(axis.tlast), 32'd0);
        checkOutput("rs_dropcnt", 32'(dropCnt), 32'd0);
        checkOutput("rs_tkeep", 32'(axis.tkeep), 32'hF);
        rstn        = 1'b1;
        axis.tready = 1'b1;
        @(negedge clk);
        wordsInPkt  = 32'd2;
        expWords[0] = 32'hBEEF_0001;
        expWords[1] = 32'hBEEF_0002;
        applyStimulus(expWords[0]);
        applyStimulus(expWords[1]);
        expectPacket(2, "post_rst");
        checkOutput("post_rst_end", 32'(axis.tvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
